// File: rtl/reg8_write_arbiter.sv
// Round-robin write arbiter that owns a shared WIDTH-bit register.
// Requesters compete for write access. A granted requester may hold the
// register with its lock bit and then perform back-to-back writes. If the
// lock holder stays idle for LOCK_MAX cycles, it is released by force.
// clr returns the register and all arbitration state to their reset values.
module reg8_write_arbiter #(
  parameter int               NREQ      = 4,
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               LOCK_MAX  = 15
) (
  input  logic                          clk,
  input  logic                          areset_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               lock,
  input  logic [NREQ*WIDTH-1:0]         wdata,
  input  logic                          clr,
  output logic [WIDTH-1:0]              q,
  output logic [NREQ-1:0]               gnt,
  output logic [$clog2(NREQ)-1:0]       owner,
  output logic                          busy
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state;
  logic [OW-1:0]   ptr;
  logic [7:0]      idle_cnt;

  logic            win_vld;
  logic [OW-1:0]   win_idx;
  logic [OW-1:0]   sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic            sel_req;
  logic            sel_lock;
  logic [7:0]      idle_inc;
  int              pos;
  logic [OW-1:0]   cand;

  // Successor of a requester index, wrapping at NREQ-1.
  function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] idx);
    if (idx == OW'(NREQ - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // One-hot acknowledge vector for a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

  // Round-robin search for the first active request at or after ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    pos     = 0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      cand = OW'(pos);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Selects the requester the current state listens to, and picks out its
  // request, lock qualifier and data slice. The idle counter saturates.
  always_comb begin
    sel_idx  = (state == ARB) ? win_idx : owner;
    sel_data = '0;
    sel_req  = 1'b0;
    sel_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (OW'(i) == sel_idx) begin
        sel_data = wdata[i*WIDTH +: WIDTH];
        sel_req  = req[i];
        sel_lock = lock[i];
      end
    end
    idle_inc = (idle_cnt >= 8'(LOCK_MAX)) ? idle_cnt : idle_cnt + 8'd1;
  end

  // Arbitration FSM. This block also owns the shared register and all
  // registered outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state    <= ARB;
      q        <= RESET_VAL;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      idle_cnt <= '0;
    end else if (clr) begin
      state    <= ARB;
      q        <= RESET_VAL;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (win_vld) begin
            q     <= sel_data;
            gnt   <= onehot(win_idx);
            owner <= win_idx;
            if (sel_lock) begin
              // Keep ptr so that a released lock resumes fair rotation.
              state    <= LOCKED;
              busy     <= 1'b1;
              idle_cnt <= '0;
            end else begin
              ptr <= inc_mod(win_idx);
            end
          end else begin
            gnt <= '0;
          end
        end
        LOCKED: begin
          if (sel_req) begin
            q        <= sel_data;
            gnt      <= onehot(owner);
            idle_cnt <= '0;
            if (!sel_lock) begin
              state <= ARB;
              busy  <= 1'b0;
              ptr   <= inc_mod(owner);
            end
          end else begin
            gnt      <= '0;
            idle_cnt <= idle_inc;
            if (idle_inc == 8'(LOCK_MAX)) begin
              // The owner went quiet for too long, so hand the register back.
              state <= ARB;
              busy  <= 1'b0;
              ptr   <= inc_mod(owner);
            end
          end
        end
        default: begin
          state <= ARB;
          busy  <= 1'b0;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Testbench for reg8_write_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural reference model.
module tb_reg8_write_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int LOCK_MAX = 3;
  localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;

  logic                    clk = 1'b0;
  logic                    areset_n;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         lock;
  logic [NREQ*WIDTH-1:0]   wdata;
  logic                    clr;
  logic [WIDTH-1:0]        q;
  logic [NREQ-1:0]         gnt;
  logic [1:0]              owner;
  logic                    busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state, written directly from the arbitration rules
  int m_q, m_gnt, m_owner, m_ptr, m_idle;
  bit m_locked;

  reg8_write_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .RESET_VAL(RESET_VAL), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .areset_n(areset_n), .req(req), .lock(lock), .wdata(wdata),
    .clr(clr), .q(q), .gnt(gnt), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int slice(input int i);
    return int'(wdata[i*WIDTH +: WIDTH]);
  endfunction

  task automatic model_reset();
    m_q = int'(RESET_VAL); m_gnt = 0; m_owner = 0; m_ptr = 0;
    m_idle = 0; m_locked = 0;
  endtask

  // One rising edge of the reference model, using the current inputs
  task automatic model_edge();
    int w;
    if (clr) begin
      model_reset();
    end else if (!m_locked) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        m_q = slice(w); m_gnt = 1 << w; m_owner = w;
        if (lock[w]) begin m_locked = 1; m_idle = 0; end
        else m_ptr = (w + 1) % NREQ;
      end else begin
        m_gnt = 0;
      end
    end else if (req[m_owner]) begin
      m_q = slice(m_owner); m_gnt = 1 << m_owner; m_idle = 0;
      if (!lock[m_owner]) begin m_locked = 0; m_ptr = (m_owner + 1) % NREQ; end
    end else begin
      m_gnt = 0;
      if (m_idle < LOCK_MAX) m_idle++;
      if (m_idle == LOCK_MAX) begin m_locked = 0; m_ptr = (m_owner + 1) % NREQ; end
    end
  endtask

  task automatic check_model(input string tag);
    check_val({tag, ".q"}, int'(q), m_q);
    check_val({tag, ".gnt"}, int'(gnt), m_gnt);
    check_val({tag, ".owner"}, int'(owner), m_owner);
    check_val({tag, ".busy"}, int'(busy), int'(m_locked));
  endtask

  // Advance one edge, update the model, and compare just after the edge
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic set_wdata(input int base);
    for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 8'(base + i);
  endtask

  initial begin
    areset_n = 1'b0; req = '0; lock = '0; clr = 1'b0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("por");
    @(negedge clk);
    areset_n = 1'b1;

    // Load 0x5A and enter LOCKED so that reset has a grant and busy to clear
    wdata[0*WIDTH +: WIDTH] = 8'h5A; req = 4'b0001; lock = 4'b0001;
    tick("preload");
    check_val("preload_q", int'(q), 8'h5A);
    check_val("preload_busy", int'(busy), 1);
    #2 areset_n = 1'b0;
    #1;
    model_reset();
    check_val("async_rst.q", int'(q), 0);
    check_val("async_rst.gnt", int'(gnt), 0);
    check_val("async_rst.busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    check_model("rst_hold");
    @(negedge clk);
    areset_n = 1'b1;
    req = '0; lock = '0;

    // With a single requester, the grant lasts one cycle and q holds afterwards
    wdata = '0; wdata[2*WIDTH +: WIDTH] = 8'h3C; req = 4'b0100;
    tick("single");
    check_val("single_q", int'(q), 8'h3C);
    check_val("single_gnt", int'(gnt), 4'b0100);
    check_val("single_owner", int'(owner), 2);
    req = '0;
    tick("single_idle");
    check_val("single_idle_q", int'(q), 8'h3C);
    check_val("single_idle_gnt", int'(gnt), 0);

    // Round-robin rotation with every requester active
    clr = 1'b1; tick("rr_clr"); clr = 1'b0;
    set_wdata(8'h10); req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick("rr");
      check_val("rr_gnt", int'(gnt), 1 << (k % 4));
      check_val("rr_q", int'(q), 8'h10 + (k % 4));
    end

    // Requester 1 locks on its grant, keeps ownership, then releases
    clr = 1'b1; tick("lk_clr"); clr = 1'b0;
    tick("lk_g0");
    check_val("lk_g0_gnt", int'(gnt), 4'b0001);
    lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick("lk_hold");
      check_val("lk_hold_gnt", int'(gnt), 4'b0010);
      check_val("lk_hold_busy", int'(busy), 1);
    end
    lock = '0;
    tick("lk_rel");
    check_val("lk_rel_gnt", int'(gnt), 4'b0010);
    check_val("lk_rel_busy", int'(busy), 0);
    tick("lk_next");
    check_val("lk_next_gnt", int'(gnt), 4'b0100);

    // An idle lock holder is released after LOCK_MAX cycles
    clr = 1'b1; tick("to_clr"); clr = 1'b0;
    req = 4'b0001; lock = 4'b0001;
    tick("to_lock");
    check_val("to_lock_busy", int'(busy), 1);
    req = 4'b1000; lock = '0;
    for (int k = 0; k < LOCK_MAX; k++) begin
      tick("to_idle");
      check_val("to_idle_gnt", int'(gnt), 0);
      check_val("to_idle_busy", int'(busy), (k < LOCK_MAX - 1) ? 1 : 0);
    end
    tick("to_arb");
    check_val("to_arb_gnt", int'(gnt), 4'b1000);
    check_val("to_arb_q", int'(q), 8'h13);

    // clr wins over a locked owner and over simultaneous requests
    req = 4'b1111; lock = 4'b1111;
    clr = 1'b1; tick("cc_clr0"); clr = 1'b0;
    tick("cc_lock");
    check_val("cc_lock_busy", int'(busy), 1);
    clr = 1'b1;
    tick("cc_clr");
    check_val("cc_clr_q", int'(q), int'(RESET_VAL));
    check_val("cc_clr_gnt", int'(gnt), 0);
    check_val("cc_clr_busy", int'(busy), 0);
    clr = 1'b0; lock = '0;
    tick("cc_after");
    check_val("cc_after_gnt", int'(gnt), 4'b0001);

    // Random traffic, with occasional clr and mid-cycle asynchronous resets
    for (int n = 0; n < 600; n++) begin
      req   = 4'($urandom);
      lock  = 4'($urandom) & 4'($urandom);
      wdata = 32'($urandom);
      clr   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #1 areset_n = 1'b0;
        #1;
        model_reset();
        check_val("rnd_rst.q", int'(q), int'(RESET_VAL));
        check_val("rnd_rst.gnt", int'(gnt), 0);
        check_val("rnd_rst.busy", int'(busy), 0);
        #1 areset_n = 1'b1;
      end
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg8_write_arbiter.md
Name: reg8_write_arbiter

Overview:
- Round-robin write arbiter that shares one 8-bit register among NREQ requesters. Provides an optional lock so one requester can perform back-to-back writes, and a synchronous clear.
- Owns the register itself: asynchronous active-low reset, value exposed on q.
- Sits in front of the shared 8-bit register used by the surrounding datapath; replaces ad-hoc muxing of d into that register.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register/data width.
- RESET_VAL, 0, value of q after reset and after clr.
- LOCK_MAX, 15, idle cycles allowed in LOCKED before forced release (1..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- areset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester write request, level.
- lock  in  NREQ  per-requester lock-hold qualifier; sampled only with that requester's granted write.
- wdata  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- clr  in  1  synchronous clear of q and arbitration state.
- q  out  WIDTH  register value.
- gnt  out  NREQ  registered one-hot write acknowledge, high for exactly 1 cycle.
- owner  out  clog2(NREQ)  index of the last granted requester.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset (areset_n low, asynchronous, takes effect immediately with no clock edge):
  - q=RESET_VAL, gnt=0, owner=0, busy=0.
  - Round-robin pointer ptr=0, idle counter=0, state ARB.
- States: ARB, LOCKED.
- ARB, each edge with no clr:
  - Winner w = first i with req[i]=1, searching ptr, ptr+1, …, NREQ-1, 0, … (modulo NREQ).
  - If a winner exists: q<=wdata[w], gnt<=onehot(w), owner<=w.
    - lock[w]=1: go to LOCKED, idle counter<=0, ptr unchanged.
    - lock[w]=0: stay in ARB, ptr<=(w+1) mod NREQ.
  - If no req: gnt<=0, everything else holds.
- LOCKED, each edge with no clr:
  - Only req[owner] is honoured; all other requests are ignored and get no gnt.
  - req[owner]=1: q<=wdata[owner], gnt<=onehot(owner), idle counter<=0.
    - lock[owner]=0: go to ARB, ptr<=(owner+1) mod NREQ.
    - lock[owner]=1: stay in LOCKED.
  - req[owner]=0: gnt<=0, idle counter+1.
    - When the counter reaches LOCK_MAX: forced release to ARB, ptr<=(owner+1) mod NREQ, q unchanged.
- busy = (state==LOCKED), registered, so it is coincident with the state.
- Latency:
  - Request sampled at edge k: q and gnt update at edge k, visible in cycle k..k+1.
  - A requester holding req continuously is rewritten every cycle it wins.
  - gnt therefore marks the cycle in which q already holds that requester's data.
- clr, highest priority in any state:
  - q<=RESET_VAL, gnt<=0, ptr<=0, owner<=0, state<=ARB, idle counter<=0.
  - Simultaneous requests are dropped (no gnt).
- Fairness: with all req high and lock low, grants rotate 0,1,…,NREQ-1,0; no requester waits more than NREQ-1 grants.
- Deassertion: deasserting req of a non-winner has no side effect; the arbiter keeps no pending queue.
- Reset mid-operation: areset_n low in LOCKED or mid-grant immediately clears q, gnt and busy; after release the first grant goes to the lowest-indexed requester.
- Width rule: wdata slices are used unmodified; no arithmetic on data. Idle counter is 8 bits, saturating at LOCK_MAX.

Test Plan:
- Reset: drive areset_n low between clock edges with q=0x5A → q=0x00, gnt=0, busy=0 before the next rising edge; edges while areset_n is low change nothing.
- Single requester: req=0b0100, wdata[2]=0x3C, lock=0 → next edge q=0x3C, gnt=0b0100 for one cycle, owner=2; req low after → gnt=0, q holds 0x3C.
- Round-robin: req=0b1111, wdata i = 0x10+i, lock=0, 8 edges → gnt sequence 0001,0010,0100,1000,0001,…; q sequence 0x10,0x11,0x12,0x13,0x10,…
- Lock: req=0b1111, lock[1]=1 from second grant:
  - Requester 1 gets every subsequent gnt and busy=1.
  - Drop lock[1] with req[1]=1 → that write is granted, busy=0, next gnt=0b0100.
- Lock timeout: with LOCK_MAX=3, lock owner 0 then drop req[0] while req[3]=1 → 3 idle cycles with gnt=0, then ARB, next gnt=0b1000 with q=wdata[3].
- clr collision: in LOCKED with req=0b1111, assert clr for one edge → q=RESET_VAL, gnt=0, busy=0; next edge gnt=0b0001.
